cache_refill_ctrl: RTL and testbench

Miss-handling engine that sits directly below the instruction and data caches of the five-stage pipeline. On a cache miss it fetches the 8-word (256-bit) line containing the missed word from word-addressed backing memory over a 32-bit req/ack bus. It assembles the line and hands it to the cache with a one-cycle pulse. While busy it asserts `stall`, which the PC / IF_ID / pipeline-register hold logic uses to freeze the pipeline.

---
 rtl/cache_pkg.sv | 16 +
 rtl/refill_line_buf.sv | 38 +++
 rtl/cache_refill_ctrl.sv | 176 +++++++++++++++++
 tb/tb_cache_refill_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and constants for the cache miss/refill engine and its line buffer.
package cache_pkg;
   localparam int WORDS_PER_LINE = 8;
   localparam int LINE_W         = 32 * WORDS_PER_LINE;
   localparam int BEAT_W         = 3;

   localparam logic [BEAT_W-1:0] LAST_BEAT     = BEAT_W'(WORDS_PER_LINE - 1);
   localparam logic [31:0]       LINE_OFS_MASK = 32'(WORDS_PER_LINE - 1);

   typedef enum logic [1:0] {
      REFILL_IDLE,
      REFILL_WB,
      REFILL_RD,
      REFILL_DONE
   } refill_state_t;
endpackage

// File: rtl/refill_line_buf.sv
// Line register: whole-line load, per-beat word write, synchronous clear, per-beat word read.
// Latency: loads/writes visible the cycle after the edge; the word read is combinational.
// Backpressure: none; the owner qualifies every write with its own beat handshake.
module refill_line_buf
   import cache_pkg::*;
#(
   parameter int WORD_W = 32,
   parameter int WORDS  = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clr,
   input  logic                    ld_en,
   input  logic [WORDS*WORD_W-1:0] ld_line,
   input  logic                    wr_en,
   input  logic [BEAT_W-1:0]       wr_idx,
   input  logic [WORD_W-1:0]       wr_dat,
   input  logic [BEAT_W-1:0]       rd_idx,
   output logic [WORD_W-1:0]       rd_dat,
   output logic [WORDS*WORD_W-1:0] line_dat
);
   logic [WORDS-1:0][WORD_W-1:0] line_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         line_q <= '0;
      end else if (clr) begin
         line_q <= '0;
      end else if (ld_en) begin
         line_q <= ld_line;
      end else if (wr_en) begin
         line_q[wr_idx] <= wr_dat;
      end
   end

   assign rd_dat   = line_q[rd_idx];
   assign line_dat = line_q;
endmodule

// File: rtl/cache_refill_ctrl.sv
// Cache miss engine: optional dirty-victim writeback (CACHE_WRITEBACK_EN) then an 8-beat line refill.
// Latency: refill_valid 9 cycles (clean) / 17 cycles (dirty) after the miss, +1 per cycle without mem_ack.
// Backpressure: memory throttles each beat via mem_ack; stall holds the pipeline whenever not idle.
module cache_refill_ctrl
   import cache_pkg::*;
#(
   parameter int  ADDR_W         = 32,
   parameter int  WORD_W         = 32,
   parameter int  WORDS_PER_LINE = cache_pkg::WORDS_PER_LINE,
   localparam int LINE_W         = WORD_W * WORDS_PER_LINE
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              miss_req,
   input  logic [ADDR_W-1:0] miss_addr,
   input  logic              victim_dirty,
   input  logic [ADDR_W-1:0] victim_addr,
   input  logic [LINE_W-1:0] victim_line,
   output logic              stall,
   output logic [LINE_W-1:0] refill_line,
   output logic              refill_valid,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [WORD_W-1:0] mem_rdata
);
   localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_OFS_MASK);

   refill_state_t     state_q, state_d;
   logic [BEAT_W-1:0] beat_q;
   logic [ADDR_W-1:0] base_q;
   logic              beat_vld;
   logic              last_beat;
   logic              miss_take;
   logic              wb_start;
   logic              rd_wr_en;
   logic [WORD_W-1:0] refill_rd_unused;

   assign beat_vld  = mem_req & mem_ack;
   assign last_beat = (beat_q == LAST_BEAT);
   assign miss_take = (state_q == REFILL_IDLE) & miss_req;
   assign rd_wr_en  = (state_q == REFILL_RD) & beat_vld;

`ifdef CACHE_WRITEBACK_EN
   logic [ADDR_W-1:0] vict_addr_q;
   logic [WORD_W-1:0] vict_wdat;
   logic [LINE_W-1:0] vict_line_unused;
   logic              vict_ld;
   logic              vict_clr;

   assign wb_start = victim_dirty;
   assign vict_ld  = miss_take & victim_dirty;
   // Drop the victim copy once it has been fully written out.
   assign vict_clr = (state_q == REFILL_WB) & beat_vld & last_beat;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vict_addr_q <= '0;
      end else if (vict_ld) begin
         vict_addr_q <= victim_addr;
      end
   end

   refill_line_buf #(
      .WORD_W (WORD_W),
      .WORDS  (WORDS_PER_LINE)
   ) u_victim_buf (
      .clk      (clk),
      .reset    (reset),
      .clr      (vict_clr),
      .ld_en    (vict_ld),
      .ld_line  (victim_line),
      .wr_en    (1'b0),
      .wr_idx   ('0),
      .wr_dat   ('0),
      .rd_idx   (beat_q),
      .rd_dat   (vict_wdat),
      .line_dat (vict_line_unused)
   );
`else
   logic victim_unused;

   assign victim_unused = ^{victim_dirty, victim_addr, victim_line};
   assign wb_start      = 1'b0;
`endif

   refill_line_buf #(
      .WORD_W (WORD_W),
      .WORDS  (WORDS_PER_LINE)
   ) u_refill_buf (
      .clk      (clk),
      .reset    (reset),
      .clr      (1'b0),
      .ld_en    (1'b0),
      .ld_line  ('0),
      .wr_en    (rd_wr_en),
      .wr_idx   (beat_q),
      .wr_dat   (mem_rdata),
      .rd_idx   (beat_q),
      .rd_dat   (refill_rd_unused),
      .line_dat (refill_line)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= REFILL_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Counter wraps to zero on the last beat, which also re-arms it for RD after WB.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         beat_q <= '0;
         base_q <= '0;
      end else if (miss_take) begin
         beat_q <= '0;
         base_q <= miss_addr & LINE_MASK;
      end else if (beat_vld) begin
         beat_q <= last_beat ? '0 : beat_q + BEAT_W'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         REFILL_IDLE: begin
            if (miss_req) begin
               state_d = wb_start ? REFILL_WB : REFILL_RD;
            end
         end
`ifdef CACHE_WRITEBACK_EN
         REFILL_WB: begin
            if (beat_vld && last_beat) begin
               state_d = REFILL_RD;
            end
         end
`endif
         REFILL_RD: begin
            if (beat_vld && last_beat) begin
               state_d = REFILL_DONE;
            end
         end
         REFILL_DONE: state_d = REFILL_IDLE;
         default:     state_d = REFILL_IDLE;
      endcase
   end

   always_comb begin
      stall        = (state_q != REFILL_IDLE);
      refill_valid = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      case (state_q)
`ifdef CACHE_WRITEBACK_EN
         REFILL_WB: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = vict_addr_q + ADDR_W'(beat_q);
            mem_wdata = vict_wdat;
         end
`endif
         REFILL_RD: begin
            mem_req  = 1'b1;
            mem_addr = base_q + ADDR_W'(beat_q);
         end
         REFILL_DONE: refill_valid = 1'b1;
         default: ;
      endcase
   end
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed + randomized bench for cache_refill_ctrl with a behavioural memory and line model.
module tb_cache_refill_ctrl;
   localparam int ADDR_W = 32;
   localparam int WORD_W = 32;
   localparam int LINE_W = 256;
`ifdef CACHE_WRITEBACK_EN
   localparam bit WB_ON = 1'b1;
`else
   localparam bit WB_ON = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              miss_req = 1'b0;
   logic [ADDR_W-1:0] miss_addr = '0;
   logic              victim_dirty = 1'b0;
   logic [ADDR_W-1:0] victim_addr = '0;
   logic [LINE_W-1:0] victim_line = '0;
   logic              stall, refill_valid, mem_req, mem_we;
   logic [LINE_W-1:0] refill_line;
   logic [ADDR_W-1:0] mem_addr;
   logic [WORD_W-1:0] mem_wdata, mem_rdata;
   logic              mem_ack = 1'b0;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int t0 = 0;
   bit ack_pat [128];
   bit mem_mode = 1'b0;
   logic [31:0] salt = '0;
   logic [LINE_W-1:0] last_line = '0;

   logic [64:0] log_beat [$];
   int          vld_cyc [$];
   int          we_hi = 0;
   int          unstable = 0;
   logic        prev_wait = 1'b0;
   logic [64:0] prev_cmd = '0;

   cache_refill_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .miss_req     (miss_req),
      .miss_addr    (miss_addr),
      .victim_dirty (victim_dirty),
      .victim_addr  (victim_addr),
      .victim_line  (victim_line),
      .stall        (stall),
      .refill_line  (refill_line),
      .refill_valid (refill_valid),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_ack      (mem_ack),
      .mem_rdata    (mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_val(input logic [31:0] a, input bit mode, input logic [31:0] s);
      return mode ? ((a * 32'h9E37_79B1) ^ s) : (32'hA0 + a);
   endfunction

   function automatic bit ack_at(input int k);
      return (k < 1 || k >= 128) ? 1'b1 : ack_pat[k];
   endfunction

   // Cycle (relative to the miss) of refill_valid: one past the cycle of the n-th acknowledged beat.
   function automatic int exp_vld(input int nbeats);
      int k, cnt;
      k = 0;
      cnt = 0;
      while (cnt < nbeats) begin
         k++;
         if (ack_at(k)) cnt++;
      end
      return k + 1;
   endfunction

   always_comb mem_rdata = mem_val(mem_addr, mem_mode, salt);

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      mem_ack = ack_at(cyc - t0);
   end

   always @(negedge clk) begin
      logic [64:0] cmd;
      cmd = {mem_addr, mem_we, (mem_we ? mem_wdata : 32'h0)};
      if (mem_we) we_hi++;
      if (mem_req && prev_wait && cmd !== prev_cmd) unstable++;
      if (mem_req && mem_ack) log_beat.push_back(cmd);
      if (refill_valid) vld_cyc.push_back(cyc);
      prev_wait = reset && mem_req && !mem_ack;
      prev_cmd  = cmd;
   end

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_miss(input logic [31:0] a, input bit dirty, input logic [31:0] va,
                           input logic [255:0] vl, input int drop_at, input int rst_at, input bit hold);
      logic [31:0]  base;
      logic [255:0] exp_line;
      logic [64:0]  exp_beat [$];
      logic [64:0]  ob;
      int           ev, tv, stall_bad;
      base = a & ~32'h7;
      for (int i = 0; i < 8; i++) exp_line[32*i +: 32] = mem_val(base + 32'(i), mem_mode, salt);
      if (dirty && WB_ON)
         for (int i = 0; i < 8; i++) exp_beat.push_back({va + 32'(i), 1'b1, vl[32*i +: 32]});
      for (int i = 0; i < 8; i++) exp_beat.push_back({base + 32'(i), 1'b0, 32'h0});
      ev = exp_vld(exp_beat.size());
      log_beat.delete();
      vld_cyc.delete();
      we_hi = 0;
      unstable = 0;
      stall_bad = 0;
      tv = -1;
      miss_addr = a;
      victim_dirty = dirty;
      victim_addr = va;
      victim_line = vl;
      miss_req = 1'b1;
      t0 = cyc;
      for (int k = 1; k <= 400 && tv < 0; k++) begin
         @(negedge clk);
         #1;
         if (k == 1) chk("line_held_until_first_beat", refill_line, last_line);
         if (k == rst_at) begin
            reset = 1'b0;
            #1;
            chk("rst_req_stall_vld", {mem_req, stall, refill_valid}, 3'b000);
            chk("rst_line_zero", refill_line, '0);
            miss_req = 1'b0;
            repeat (3) @(negedge clk);
            #1 reset = 1'b1;
            repeat (2) @(negedge clk);
            #1;
            chk("rst_no_pulse", vld_cyc.size(), 0);
            last_line = '0;
            return;
         end
         if (k == drop_at) miss_req = 1'b0;
         if (stall !== (k <= ev)) stall_bad++;
         if (vld_cyc.size() != 0) tv = vld_cyc[0] - t0;
      end
      chk("vld_cycle", tv, ev);
      chk("refill_line", refill_line, exp_line);
      chk("beat_count", log_beat.size(), exp_beat.size());
      for (int i = 0; i < exp_beat.size(); i++) begin
         ob = 'x;
         if (i < log_beat.size()) ob = log_beat[i];
         chk("beat_addr_we_wdata", ob, exp_beat[i]);
      end
      chk("stall_window", stall_bad, 0);
      chk("we_seen", we_hi != 0, dirty && WB_ON);
      chk("cmd_stable_while_waiting", unstable, 0);
      last_line = exp_line;
      @(negedge clk);
      #1;
      chk("idle_after_pulse", {stall, refill_valid, mem_req}, 3'b000);
      chk("line_kept_after_done", refill_line, exp_line);
      if (!hold) miss_req = 1'b0;
   endtask

   initial begin
      logic [255:0] vl;
      logic [31:0]  ra, rva;
      bit           rd;

      #2 reset = 1'b0;
      #1;
      chk("rst_stall", stall, 1'b0);
      chk("rst_refill_valid", refill_valid, 1'b0);
      chk("rst_mem_req_we", {mem_req, mem_we}, 2'b00);
      chk("rst_mem_addr", mem_addr, '0);
      chk("rst_mem_wdata", mem_wdata, '0);
      chk("rst_refill_line", refill_line, '0);
      repeat (3) @(negedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      #1;

      // Clean miss, zero-wait memory.
      foreach (ack_pat[k]) ack_pat[k] = 1'b1;
      run_miss(32'h13, 1'b0, '0, '0, 0, 0, 1'b0);

      // Ack only every third cycle.
      foreach (ack_pat[k]) ack_pat[k] = (k % 3 == 0);
      run_miss(32'h13, 1'b0, '0, '0, 0, 0, 1'b0);

      // Dirty victim at 0x40, word i = 0x1000+i.
      foreach (ack_pat[k]) ack_pat[k] = 1'b1;
      for (int i = 0; i < 8; i++) vl[32*i +: 32] = 32'h1000 + 32'(i);
      run_miss(32'h13, 1'b1, 32'h40, vl, 0, 0, 1'b0);

      // Reset during RD beat 4, then a fresh refill.
      run_miss(32'h13, 1'b0, '0, '0, 0, 5, 1'b0);
      run_miss(32'h13, 1'b0, '0, '0, 0, 0, 1'b0);

      // miss_req dropped mid-refill.
      run_miss(32'h2B, 1'b0, '0, '0, 3, 0, 1'b0);

      // miss_req held past the pulse starts a back-to-back refill.
      run_miss(32'h25, 1'b0, '0, '0, 0, 0, 1'b1);
      run_miss(32'h88, 1'b0, '0, '0, 0, 0, 1'b0);

      // Randomized misses, victims and ack patterns.
      mem_mode = 1'b1;
      salt = $urandom;
      for (int r = 0; r < 10; r++) begin
         foreach (ack_pat[k]) ack_pat[k] = ($urandom_range(0, 99) < 60);
         ra  = (r == 3) ? 32'hFFFF_FFFB : $urandom;
         rva = (r == 5) ? 32'hFFFF_FFF8 : ($urandom & ~32'h7);
         rd  = 1'($urandom_range(0, 1));
         for (int i = 0; i < 8; i++) vl[32*i +: 32] = $urandom;
         run_miss(ra, rd, rva, vl, 0, 0, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete, %0d vectors applied", n_vec);
      $fatal(1, "watchdog expired");
   end
endmodule
